ethernet_frame_parser: RTL and testbench
========================================

ETHERNET_FRAME_PARSER -- requirements
Module: ethernet_frame_parser

Interface
REQ-001 DATA_WIDTH, default 64, stream data width in bits; only 64 is supported, other values are a compile-time error.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 s_axis_tdata  input  DATA_WIDTH  ingress frame beat; wire byte 0 at bits [63:56].
REQ-005 s_axis_tvalid  input  1  ingress beat valid.
REQ-006 s_axis_tready  output  1  ingress ready.
REQ-007 s_axis_tlast  input  1  last beat of frame.
REQ-008 m_axis_tdata  output  DATA_WIDTH  egress beat, bit-identical to ingress.
REQ-009 m_axis_tvalid  output  1  egress valid.
REQ-010 m_axis_tready  input  1  egress ready; may toggle every cycle.
REQ-011 m_axis_tlast  output  1  egress last, travels with its beat.
REQ-012 m_axis_tuser  output  eth_metadata_t  parsed header metadata of the most recent completed frame.
REQ-013 m_axis_tuser_valid  output  1  one-cycle pulse marking new m_axis_tuser.

Function
REQ-014 Datapath SHALL forward every accepted ingress beat exactly once, in order, with tdata/tlast unmodified; no drop, duplication or reordering under any tready pattern.
REQ-015 Transfer occurs on a side only when valid and ready are both high at a rising edge.
REQ-016 Datapath SHALL be a 2-entry skid buffer: s_axis_tready registered, high while fewer than 2 entries held; sustained 1 beat/cycle when m_axis_tready stays high.
REQ-017 Latency: beat accepted in cycle N appears on m_axis_* no earlier than cycle N+1; m_axis_tdata/tlast stable while m_axis_tvalid high and m_axis_tready low.
REQ-018 Simultaneous ingress accept and egress accept SHALL keep occupancy unchanged.
REQ-019 Parser tracks beat index per frame (0,1,2,...), counted on ingress accepts, reset to 0 after a tlast accept.
REQ-020 Beat 0: dst_mac = bytes 0-5, src_mac[47:32] = bytes 6-7.
REQ-021 Beat 1: src_mac[31:0] = bytes 0-3, ethertype = bytes 4-5; if ethertype == 16'h8100 then vlan_valid = 1, vlan_tci = bytes 6-7.
REQ-022 Beat 2 (VLAN only): inner ethertype = bytes 0-1, replacing ethertype; vlan_valid frames report inner type.
REQ-023 beat_count (16-bit, saturating at 16'hFFFF) = number of beats in the frame.
REQ-024 truncated = 1 when the frame ends before the ethertype (or VLAN inner type) is captured; missing fields read as 0.
REQ-025 Metadata fields for a frame SHALL start cleared at its beat 0.
REQ-026 m_axis_tuser_valid SHALL pulse high for exactly one cycle, the cycle after the tlast beat is accepted on ingress, once per frame, independent of m_axis_tready.
REQ-027 m_axis_tuser updates in the same cycle as the pulse and holds until the next pulse.
REQ-028 Single-beat frame (tlast on beat 0) SHALL still produce one pulse with truncated = 1, beat_count = 1.
REQ-029 Back-to-back frames (tlast followed next cycle by new beat 0) SHALL yield one pulse per frame, none merged or lost.

Reset
REQ-030 While rst high: s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tuser_valid = 0, skid buffer empty, beat index 0.
REQ-031 Reset asserted mid-frame SHALL discard buffered beats and partial metadata; first accepted beat after release is beat 0.
REQ-032 s_axis_tready SHALL rise on the first clock edge after rst deasserts.

Structure
REQ-033 Package eth_parser_pkg SHALL hold eth_metadata_t (packed: dst_mac 48, src_mac 48, ethertype 16, vlan_valid 1, vlan_tci 16, beat_count 16, truncated 1) and constant ETH_TYPE_VLAN = 16'h8100.
REQ-034 Skid buffer SHALL be a sub-module axis_skid_buffer (parameter DATA_WIDTH, carries data+last); header parser and metadata logic live in ethernet_frame_parser.

Verification
REQ-035 Frame beats 64'h0011223344556677, 64'h8899AABB08000000, 64'h0 (last), tready=1 -> same three beats out; one pulse with dst_mac=48'h001122334455, src_mac=48'h66778899AABB, ethertype=16'h0800, vlan_valid=0, beat_count=3, truncated=0.
REQ-036 VLAN: beat1 64'h8899AABB8100_0064, beat2 64'h86DD000000000000 (last) -> vlan_valid=1, vlan_tci=16'h0064, ethertype=16'h86DD.
REQ-037 50 frames x 3 beats tagged {frame[15:0], beat[15:0], 32'hCAFEBABE}, random 0-3 cycle ingress gaps, m_axis_tready random each cycle -> 150 beats out in exact order, 50 pulses, each within 2000 cycles.
REQ-038 Single beat 64'hFFFFFFFFFFFF0000 with tlast -> beat forwarded, pulse with truncated=1, beat_count=1, ethertype=0.
REQ-039 m_axis_tready held 0 -> s_axis_tready drops after 2 accepted beats; releasing tready drains both in order.
REQ-040 rst asserted mid-frame with full buffer -> all outputs 0 asynchronously; next frame parsed from beat 0 correctly.

Source files
------------

// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet header parser.
// Defines the per-frame metadata record and the parser state encoding.
package eth_parser_pkg;

  localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        vlan_valid;
    logic [15:0] vlan_tci;
    logic [15:0] beat_count;
    logic        truncated;
  } eth_metadata_t;

  // Which header field group the next accepted beat carries.
  typedef enum logic [1:0] {
    PS_DST        = 2'd0,
    PS_SRC_TYPE   = 2'd1,
    PS_VLAN_INNER = 2'd2,
    PS_PAYLOAD    = 2'd3
  } parse_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer carrying data plus last.
// Upstream ready is registered and stays high while at most one entry is held.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready
);

  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
  logic                  out_last_reg, out_last_next;
  logic                  skid_last_reg, skid_last_next;
  logic                  out_valid_reg, out_valid_next;
  logic                  skid_valid_reg, skid_valid_next;
  logic                  ready_reg, ready_next;
  logic                  push, pop;

  assign push = s_valid & ready_reg;
  assign pop  = out_valid_reg & m_ready;

  // The output register is always the head; the skid register only fills
  // when a beat arrives while the head is stalled.
  always_comb begin
    out_data_next   = out_data_reg;
    out_last_next   = out_last_reg;
    out_valid_next  = out_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_last_next  = skid_last_reg;
    skid_valid_next = skid_valid_reg;
    unique case ({push, pop})
      2'b10: begin
        if (!out_valid_reg) begin
          out_data_next  = s_data;
          out_last_next  = s_last;
          out_valid_next = 1'b1;
        end else begin
          skid_data_next  = s_data;
          skid_last_next  = s_last;
          skid_valid_next = 1'b1;
        end
      end
      2'b01: begin
        if (skid_valid_reg) begin
          out_data_next   = skid_data_reg;
          out_last_next   = skid_last_reg;
          skid_valid_next = 1'b0;
        end else begin
          out_valid_next = 1'b0;
        end
      end
      2'b11: begin
        if (skid_valid_reg) begin
          out_data_next  = skid_data_reg;
          out_last_next  = skid_last_reg;
          skid_data_next = s_data;
          skid_last_next = s_last;
        end else begin
          out_data_next = s_data;
          out_last_next = s_last;
        end
      end
      default: ;
    endcase
    ready_next = ~skid_valid_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      out_data_reg   <= out_data_next;
      out_last_reg   <= out_last_next;
      out_valid_reg  <= out_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_last_reg  <= skid_last_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ready_next;
    end
  end

  assign s_ready = ready_reg;
  assign m_data  = out_data_reg;
  assign m_last  = out_last_reg;
  assign m_valid = out_valid_reg;

endmodule

// File: rtl/ethernet_frame_parser.sv
// Pass-through AXI-stream Ethernet frame parser: beats flow through a skid
// buffer while header fields are extracted from accepted ingress beats.
module ethernet_frame_parser
  import eth_parser_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output eth_metadata_t         m_axis_tuser,
  output logic                  m_axis_tuser_valid
);

  if (DATA_WIDTH != 64) begin : g_width_check
    $error("ethernet_frame_parser supports DATA_WIDTH = 64 only");
  end

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_axis_tdata),
    .s_last  (s_axis_tlast),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (m_axis_tdata),
    .m_last  (m_axis_tlast),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  // Wire byte 0 sits in the most significant lane.
  logic [7:0] beat_byte [0:7];
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_bytes
    assign beat_byte[gi] = s_axis_tdata[63 - 8*gi -: 8];
  end

  parse_state_t  state_reg, state_next;
  eth_metadata_t meta_reg, meta_next;
  eth_metadata_t tuser_reg;
  logic          tuser_valid_reg;
  logic          in_fire;

  assign in_fire = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_next = state_reg;
    meta_next  = (state_reg == PS_DST) ? '0 : meta_reg;
    if (in_fire) begin
      meta_next.beat_count = sat_inc16(meta_next.beat_count);
      meta_next.truncated  = 1'b0;
      unique case (state_reg)
        PS_DST: begin
          meta_next.dst_mac = {beat_byte[0], beat_byte[1], beat_byte[2],
                               beat_byte[3], beat_byte[4], beat_byte[5]};
          meta_next.src_mac[47:32] = {beat_byte[6], beat_byte[7]};
          meta_next.truncated      = 1'b1;
          state_next               = PS_SRC_TYPE;
        end
        PS_SRC_TYPE: begin
          meta_next.src_mac[31:0] = {beat_byte[0], beat_byte[1],
                                     beat_byte[2], beat_byte[3]};
          if ({beat_byte[4], beat_byte[5]} == ETH_TYPE_VLAN) begin
            // Tagged: the reported type is the inner one, still pending.
            meta_next.vlan_valid = 1'b1;
            meta_next.vlan_tci   = {beat_byte[6], beat_byte[7]};
            meta_next.truncated  = 1'b1;
            state_next           = PS_VLAN_INNER;
          end else begin
            meta_next.ethertype = {beat_byte[4], beat_byte[5]};
            state_next          = PS_PAYLOAD;
          end
        end
        PS_VLAN_INNER: begin
          meta_next.ethertype = {beat_byte[0], beat_byte[1]};
          state_next          = PS_PAYLOAD;
        end
        PS_PAYLOAD: ;
        default: ;
      endcase
      if (s_axis_tlast) begin
        state_next = PS_DST;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= PS_DST;
      meta_reg        <= '0;
      tuser_reg       <= '0;
      tuser_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      meta_reg        <= meta_next;
      tuser_valid_reg <= in_fire & s_axis_tlast;
      if (in_fire && s_axis_tlast) begin
        tuser_reg <= meta_next;
      end
    end
  end

  assign m_axis_tuser       = tuser_reg;
  assign m_axis_tuser_valid = tuser_valid_reg;

endmodule

// File: tb/tb_ethernet_frame_parser.sv
// Scoreboard bench for ethernet_frame_parser: the driver queues expected beats
// and byte-offset reference metadata; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ethernet_frame_parser;
  import eth_parser_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [63:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  eth_metadata_t m_axis_tuser;
  logic          m_axis_tuser_valid;

  always #5 clk = ~clk;

  ethernet_frame_parser #(.DATA_WIDTH(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tuser_valid (m_axis_tuser_valid)
  );

  int            errors = 0;
  int            checks = 0;
  int unsigned   cyc = 0;
  int            ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  logic [64:0]   beat_q [$];
  eth_metadata_t meta_q [$];
  int unsigned   edge_q [$];
  logic [64:0]   prev_beat = '0;
  bit            prev_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference: flatten the frame to a byte string and read fields at fixed
  // Ethernet offsets; anything beyond the end of the frame reads as zero.
  function automatic eth_metadata_t ref_meta(input logic [63:0] beats [$]);
    eth_metadata_t m;
    logic [7:0]    b [$];
    logic [15:0]   t;
    int            n;
    m = '0;
    n = beats.size();
    foreach (beats[i]) for (int k = 7; k >= 0; k--) b.push_back(beats[i][8*k +: 8]);
    for (int i = 0; i < 6; i++)  m.dst_mac = {m.dst_mac[39:0], b[i]};
    for (int i = 6; i < 12; i++) m.src_mac = {m.src_mac[39:0], (i < b.size()) ? b[i] : 8'h00};
    m.beat_count = (n > 65535) ? 16'hFFFF : 16'(n);
    m.truncated  = 1'b1;
    if (n >= 2) begin
      t = {b[12], b[13]};
      if (t == 16'h8100) begin
        m.vlan_valid = 1'b1;
        m.vlan_tci   = {b[14], b[15]};
        if (n >= 3) begin
          m.ethertype = {b[16], b[17]};
          m.truncated = 1'b0;
        end
      end else begin
        m.ethertype = t;
        m.truncated = 1'b0;
      end
    end
    return m;
  endfunction

  // Egress ready pattern, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Monitor: values seen at the falling edge are those the next rising edge uses.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1'b1);
        check("hold_beat", {m_axis_tlast, m_axis_tdata}, prev_beat);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (beat_q.size() == 0) fail_now("unexpected_egress_beat");
        else check("egress_beat", {m_axis_tlast, m_axis_tdata}, beat_q.pop_front());
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tuser_valid) begin
        if (meta_q.size() == 0) fail_now("unexpected_tuser_pulse");
        else check("tuser", m_axis_tuser, meta_q.pop_front());
        if (edge_q.size() == 0) fail_now("pulse_without_tlast");
        else check("pulse_cycle", cyc, edge_q.pop_front());
      end
      if (s_axis_tvalid && s_axis_tready && s_axis_tlast) edge_q.push_back(cyc + 1);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_beat(input logic [63:0] d, input bit last, input int gap);
    int waited;
    waited = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    beat_q.push_back({last, d});
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      waited++;
      if (waited > 2000) begin
        fail_now("ingress_accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [63:0] fr [$], input int maxgap);
    meta_q.push_back(ref_meta(fr));
    for (int i = 0; i < fr.size(); i++)
      drive_beat(fr[i], (i == fr.size() - 1), int'($urandom_range(0, maxgap)));
  endtask

  task automatic wait_drain(input bit incl_meta);
    int n;
    n = 0;
    while ((beat_q.size() != 0 || (incl_meta && meta_q.size() != 0)) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) fail_now("drain_timeout");
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  logic [63:0] fr [$];
  logic [63:0] w;
  logic [15:0] tag_f;
  logic [15:0] tag_b;
  int          len;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_beat", {m_axis_tlast, m_axis_tdata}, '0);
    check("rst_tuser", m_axis_tuser, '0);
    check("rst_tuser_valid", m_axis_tuser_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("tready_before_edge", s_axis_tready, 1'b0);
    @(posedge clk);
    #1;
    check("tready_after_release", s_axis_tready, 1'b1);

    // Plain IPv4 frame
    fr = '{64'h0011223344556677, 64'h8899AABB08000000, 64'h0};
    send_frame(fr, 0);
    // VLAN-tagged frame
    fr = '{64'h0011223344556677, 64'h8899AABB81000064, 64'h86DD000000000000};
    send_frame(fr, 1);
    // Single-beat frame
    fr = '{64'hFFFFFFFFFFFF0000};
    send_frame(fr, 0);
    // Back-to-back frames with no idle cycle
    fr = '{64'h0102030405060708, 64'h090A0B0C88B50000};
    send_frame(fr, 0);
    fr = '{64'h1112131415161718};
    send_frame(fr, 0);
    fr = '{64'h2122232425262728, 64'h292A2B2C81000FFF, 64'h0800AAAAAAAAAAAA, 64'h5555};
    send_frame(fr, 0);
    wait_drain(1'b1);

    // Tagged frames under random egress backpressure
    ready_mode = 1;
    for (int f = 0; f < 50; f++) begin
      fr.delete();
      tag_f = 16'(f);
      for (int b = 0; b < 3; b++) begin
        tag_b = 16'(b);
        fr.push_back({tag_f, tag_b, 32'hCAFEBABE});
      end
      send_frame(fr, 3);
    end
    wait_drain(1'b1);

    // Random frames, some VLAN-tagged, of 1 to 5 beats
    for (int f = 0; f < 30; f++) begin
      fr.delete();
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        w = {$urandom, $urandom};
        if (i == 1 && $urandom_range(0, 1) == 1) w[31:16] = 16'h8100;
        fr.push_back(w);
      end
      send_frame(fr, 2);
    end
    wait_drain(1'b1);

    // Backpressure: ready must drop after two held beats, then drain in order
    ready_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    fr = '{64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B50000, 64'hC0C1C2C3C4C5C6C7};
    meta_q.push_back(ref_meta(fr));
    drive_beat(fr[0], 1'b0, 0);
    check("one_held_ready", s_axis_tready, 1'b1);
    drive_beat(fr[1], 1'b0, 0);
    check("full_ready_drop", s_axis_tready, 1'b0);
    check("full_m_tvalid", m_axis_tvalid, 1'b1);
    ready_mode = 0;
    wait_drain(1'b0);
    check("drained_ready", s_axis_tready, 1'b1);
    drive_beat(fr[2], 1'b1, 0);
    wait_drain(1'b1);

    // Asynchronous reset with a full buffer in the middle of a frame
    ready_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    drive_beat(64'hDEADBEEF00112233, 1'b0, 0);
    drive_beat(64'h4455667781000001, 1'b0, 0);
    s_axis_tdata  = 64'h0800000000000000;
    s_axis_tvalid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_s_tready", s_axis_tready, 1'b0);
    check("async_rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("async_rst_m_beat", {m_axis_tlast, m_axis_tdata}, '0);
    check("async_rst_tuser", m_axis_tuser, '0);
    check("async_rst_tuser_valid", m_axis_tuser_valid, 1'b0);
    s_axis_tvalid = 1'b0;
    beat_q.delete();
    meta_q.delete();
    edge_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ready_mode = 0;
    fr = '{64'h0011223344556677, 64'h8899AABB08000000, 64'h0};
    send_frame(fr, 0);
    wait_drain(1'b1);

    check("final_beat_q_empty", beat_q.size(), 0);
    check("final_meta_q_empty", meta_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
